// File: rtl/stamp_dispatcher.sv
// rtl/stamp_dispatcher.sv - oldest-first EX/MEM/WB issue and stamp write-back for the 8-slot conveyor
// Optional BUSY watchdog: define STAMP_DISPATCH_TIMEOUT_EN.
module stamp_dispatcher #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [23:0]  reg_start_flat,
  input  logic [23:0]  stamp_state_flat,
  input  logic [703:0] reg_out_flat,
  input  logic         conveyor_adv,
  output logic [23:0]  stamp_flat,
  output logic [7:0]   stamp_in,
  output logic         conveyor_hold,
  output logic         ex_valid,
  input  logic         ex_ready,
  output logic [2:0]   ex_slot,
  output logic [87:0]  ex_cmd,
  input  logic         ex_done,
  output logic         mem_valid,
  input  logic         mem_ready,
  output logic [2:0]   mem_slot,
  output logic [87:0]  mem_cmd,
  input  logic         mem_done,
  output logic         wb_valid,
  input  logic         wb_ready,
  output logic [2:0]   wb_slot,
  output logic [87:0]  wb_cmd,
  input  logic         wb_done,
  output logic [2:0]   timeout_err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BUSY, S_STAMP} state_t;

  // Channel vectors are indexed by the stage bit: 2 = EX, 1 = MEM, 0 = WB.
  logic [2:0]   ready_v, done_v, valid_v, stamping_v, err_v;
  logic [8:0]   slot_v;
  logic [263:0] cmd_v;
  logic [23:0]  ch_in_v;
  logic [71:0]  ch_flat_v;

  assign ready_v = {ex_ready, mem_ready, wb_ready};
  assign done_v  = {ex_done, mem_done, wb_done};

  for (genvar g = 0; g < 3; g++) begin : gen_ch
    state_t     state_q, state_d;
    logic [2:0] slot_q, slot_d;
    logic [2:0] pick;
    logic       found;
    logic       to_hit;

`ifdef STAMP_DISPATCH_TIMEOUT_EN
    logic [7:0] cnt_q;
    logic       err_q;

    assign to_hit = (state_q == S_BUSY) && !done_v[g] && ((cnt_q + 8'd1) == 8'(TIMEOUT_CYC));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt_q <= '0;
        err_q <= 1'b0;
      end else begin
        if (state_q == S_ISSUE && ready_v[g]) cnt_q <= '0;
        else if (state_q == S_BUSY)          cnt_q <= cnt_q + 8'd1;
        if (to_hit) err_q <= 1'b1;
      end
    end
    assign err_v[g] = err_q;
`else
    assign to_hit   = 1'b0;
    assign err_v[g] = 1'b0;
`endif

    // Later (higher) slots overwrite earlier ones, so the oldest ready slot wins.
    always_comb begin
      found = 1'b0;
      pick  = 3'd0;
      for (int k = 0; k < 8; k++) begin
        if (reg_start_flat[3*k+g]) begin
          found = 1'b1;
          pick  = 3'(k);
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_q <= S_IDLE;
        slot_q  <= 3'd0;
      end else begin
        state_q <= state_d;
        slot_q  <= slot_d;
      end
    end

    always_comb begin
      state_d = state_q;
      slot_d  = slot_q;
      // Slot 7 never shifts while an instruction in it is incomplete; saturate defensively.
      if (state_q != S_IDLE && conveyor_adv && slot_q != 3'd7)
        slot_d = slot_q + 3'd1;
      case (state_q)
        S_IDLE: begin
          if (found) begin
            state_d = S_ISSUE;
            slot_d  = (conveyor_adv && pick != 3'd7) ? pick + 3'd1 : pick;
          end
        end
        S_ISSUE: if (ready_v[g]) state_d = S_BUSY;
        S_BUSY: begin
          if (done_v[g])   state_d = S_STAMP;
          else if (to_hit) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    assign valid_v[g]          = (state_q == S_ISSUE);
    assign stamping_v[g]       = (state_q == S_STAMP);
    assign slot_v[3*g +: 3]    = slot_q;
    assign cmd_v[88*g +: 88]   = reg_out_flat[88*slot_q +: 88];
    assign ch_in_v[8*g +: 8]   = stamping_v[g] ? (8'd1 << slot_q) : 8'd0;
    assign ch_flat_v[24*g +: 24] = stamping_v[g]
        ? (24'(stamp_state_flat[3*slot_q +: 3] | 3'(1 << g)) << (3*slot_q)) : 24'd0;
  end

  assign stamp_in      = ch_in_v[23:16] | ch_in_v[15:8] | ch_in_v[7:0];
  assign stamp_flat    = ch_flat_v[71:48] | ch_flat_v[47:24] | ch_flat_v[23:0];
  assign conveyor_hold = |stamping_v;
  assign timeout_err   = err_v;

  assign ex_valid  = valid_v[2];
  assign mem_valid = valid_v[1];
  assign wb_valid  = valid_v[0];
  assign ex_slot   = slot_v[8:6];
  assign mem_slot  = slot_v[5:3];
  assign wb_slot   = slot_v[2:0];
  assign ex_cmd    = cmd_v[263:176];
  assign mem_cmd   = cmd_v[175:88];
  assign wb_cmd    = cmd_v[87:0];

endmodule

// File: doc/stamp_dispatcher.md
# stamp_dispatcher

Per-stage issue scheduler for the 8-slot instruction conveyor. Each cycle it reads the conveyor's ready matrix (`reg_start_flat`) and, for each of the three stages (execute, memory access, write-back), selects the oldest ready slot. It hands that slot's 88-bit command to the stage unit over a valid/ready handshake. When the unit reports completion, it writes the stamp back into the slot through the conveyor's `stamp_flat`/`stamp_in` port, holding the conveyor for that cycle so the stamp cannot be lost to a shift.

## Interface
Parameters:
- `TIMEOUT_CYC`, default 255: BUSY watchdog limit in cycles. Only used with `STAMP_DISPATCH_TIMEOUT_EN`.

Ports:
- `clk`  in  1  the one clock; all state changes on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `reg_start_flat`  in  24  per-slot ready bits. Slot k occupies [3k+2:3k]; bit2 = EX, bit1 = MEM, bit0 = WB.
- `stamp_state_flat`  in  24  current stamp bits [2:0] of each slot, same packing.
- `reg_out_flat`  in  704  slot contents, 88 bits per slot; slot k occupies [88k+87:88k].
- `conveyor_adv`  in  1  high when the conveyor shifts at this edge.
- `stamp_flat`  out  24  new 3-bit stamp value per slot.
- `stamp_in`  out  8  per-slot stamp write enable.
- `conveyor_hold`  out  1  high while any channel is in STAMP. It is ORed into the conveyor stop input.
- For each channel `c` in {`ex`, `mem`, `wb`}:
  - `c_valid`  out  1  command offered to the unit.
  - `c_ready`  in  1  unit accepts the command.
  - `c_slot`  out  3  tracked slot index.
  - `c_cmd`  out  88  contents of slot `c_slot`.
  - `c_done`  in  1  single-cycle completion pulse.
- `timeout_err`  out  3  sticky per-channel timeout flags, ordered {ex, mem, wb}.

## Operation
- There are three independent, identical channel FSMs. The channel bit is b = 2 for EX, 1 for MEM, 0 for WB.
- **IDLE:** scan slots 7 down to 0 and pick the highest k with `reg_start[k][b]` = 1 (oldest first).
  - If a slot is found, latch its index and go to ISSUE.
  - If `conveyor_adv` is high at that edge, latch k+1 instead of k.
- **ISSUE:**
  - `c_valid` = 1.
  - `c_cmd` = `reg_out_flat` slice at the latched index; this is a combinational mux on the registered index.
  - On `c_valid` & `c_ready`, go to BUSY.
- **BUSY:** wait for `c_done`. On `c_done`, go to STAMP.
- **STAMP:**
  - Drive `stamp_in[slot]` = 1.
  - Drive `stamp_flat[slot]` = `stamp_state[slot]` | (1<<b).
  - Drive `conveyor_hold` = 1.
  - Return to IDLE on the next edge.
- **Slot tracking:** in ISSUE, BUSY and STAMP, the index increments by 1 on every edge where `conveyor_adv` = 1.
  - An index of 7 with `conveyor_adv` high is illegal, because the conveyor stalls while slot 7 is incomplete.
  - In that case the RTL holds the index at 7, and the bench asserts that it never happens.
- **Simultaneous STAMPs:** channels in STAMP on different slots in the same cycle have their `stamp_in` bits ORed and each writes its own `stamp_flat` field. Fields with `stamp_in` = 0 drive 0.
- Two channels never stamp the same slot in the same cycle, because the stage bits of one instruction are set sequentially.
- `c_done` is ignored outside BUSY, and `c_ready` is ignored outside ISSUE.

## Timing
- **Reset:** asynchronous on `rst_n` low. All FSMs go to IDLE and all slot indices to 0. All outputs are 0, including `c_valid`, `stamp_in`, `conveyor_hold` and `timeout_err`; `c_cmd` = slot 0 contents.
- **Reset mid-operation:** `c_valid` drops immediately and no stamp is issued. The conveyor slot keeps its old stamp and is re-selected after reset.
- **Latency:**
  - Ready bit seen in IDLE to `c_valid` high: 1 cycle.
  - `c_done` to `stamp_in`: 1 cycle.
  - STAMP lasts exactly 1 cycle.
- **Minimum channel turnaround:** 4 cycles, IDLE → ISSUE → BUSY → STAMP. The next selection happens in the following IDLE cycle, which sees the updated `reg_start`.
- `c_done` may arrive at the earliest one cycle after the accepting edge.

## Configuration
- **With `STAMP_DISPATCH_TIMEOUT_EN` defined:**
  - Each channel has an 8-bit counter that clears on entry to BUSY and increments every cycle in BUSY.
  - When the counter reaches `TIMEOUT_CYC` with no `c_done`, the channel sets its `timeout_err` bit (sticky until reset) and goes to IDLE without stamping.
  - A `c_done` arriving in that same cycle wins: the channel goes to STAMP and no error is flagged.
- **Without the macro:** no counter is built, `timeout_err` is tied to 0, and BUSY waits indefinitely.

## Test plan
- **Single EX issue:** `reg_start` slot 3 = 3'b100, `ex_ready` = 1 → `ex_valid` high the next cycle with `ex_slot` = 3. `ex_done` 2 cycles later → `stamp_in` = 8'h08, `stamp_flat`[11:9] = `stamp_state`[11:9] | 3'b100, `conveyor_hold` = 1 for 1 cycle.
- **Oldest-first:** EX ready in slots 1, 4 and 6 → `ex_slot` = 6. After its stamp, the next pick is 4.
- **Shift tracking:** issue from slot 2 while `ex_ready` = 0; pulse `conveyor_adv` twice → `ex_slot` = 4 and `ex_cmd` = `reg_out_flat`[439:352]. The stamp lands on slot 4.
- **Concurrent stamps:** EX done for slot 5 and WB done for slot 7 in the same cycle → `stamp_in` = 8'hA0, both fields correct, `conveyor_hold` = 1.
- **Reset mid-BUSY:** drop `rst_n` while MEM is in BUSY → `mem_valid`, `stamp_in` and `conveyor_hold` are 0 immediately, and no stamp follows after release.
- **Timeout (macro on):** `TIMEOUT_CYC` = 255, no `mem_done` → `timeout_err` = 3'b010 after 255 BUSY cycles, no stamp issued, and the channel re-issues the same slot.
